// File: rtl/trng_sample_ctrl.sv
// ---------------------------------------------------------------------------
// trng_sample_ctrl
//
// Sampling controller for the TRNG synchronizer front end. Enables the
// ring-oscillator source, waits for the synchronizer to report valid, captures
// one synchronized bit every N rng_clk cycles and packs WORD_W captures into a
// word (first capture ends up in the MSB). Words go to the entropy buffer over
// a valid/ready handshake. A repetition-count health check shuts the source
// down when the oscillator output appears stuck.
//
// Ports:
//   rng_clk     in   block clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   pulse, begins collection from IDLE or ERR
//   stop        in   pulse, ends collection (deferred until transfer in PUSH)
//   sample_cnt  in   rng_clk cycles per captured bit, latched on start, 0 -> 1
//   rnd_src_en  out  registered source/synchronizer enable
//   sync_valid  in   synchronizer output valid
//   sync_data   in   synchronized random bit
//   out_valid   out  word available
//   out_data    out  packed word
//   out_ready   in   consumer accepts the word
//   busy        out  high outside IDLE and ERR
//   err_stuck   out  repetition-count failure, held until start or rst
// ---------------------------------------------------------------------------
module trng_sample_ctrl #(
    parameter int WORD_W    = 32,
    parameter int RPT_LIMIT = 24
) (
    input  logic              rng_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [15:0]       sample_cnt,
    output logic              rnd_src_en,
    input  logic              sync_valid,
    input  logic              sync_data,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              err_stuck
);
    localparam int              BC_W     = $clog2(WORD_W) + 1;
    localparam logic [BC_W-1:0] BC_ONE   = BC_W'(1);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
    localparam logic [7:0]      RPT_LIM  = 8'(RPT_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_SAMPLE,
        S_PUSH,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [7:0]        rpt_q, rpt_d;
    logic              last_bit_q, last_bit_d;
    logic              stop_pend_q, stop_pend_d;
    logic              en_q, en_d;
    logic [7:0]        rpt_cap;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // rpt_q == 0 marks "no capture since start", so the first capture
    // always restarts the run at 1.
    assign rpt_cap = (rpt_q == 8'd0 || sync_data != last_bit_q) ? 8'd1 : sat_inc8(rpt_q);

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rpt_d       = rpt_q;
        last_bit_d  = last_bit_q;
        stop_pend_d = stop_pend_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                // stop in the same cycle suppresses start
                if (start && !stop) begin
                    state_d     = S_WARMUP;
                    n_d         = (sample_cnt == 16'd0) ? 16'd1 : sample_cnt;
                    rpt_d       = 8'd0;
                    last_bit_d  = 1'b0;
                    stop_pend_d = 1'b0;
                end
            end
            S_WARMUP: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (sync_valid) begin
                    state_d   = S_SAMPLE;
                    cnt_d     = n_q - 16'd1;
                    bit_cnt_d = '0;
                end
            end
            S_SAMPLE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (!sync_valid) begin
                    state_d = S_WARMUP;
                end else if (cnt_q == 16'd0) begin
                    shift_d    = {shift_q[WORD_W-2:0], sync_data};
                    bit_cnt_d  = bit_cnt_q + BC_ONE;
                    cnt_d      = n_q - 16'd1;
                    rpt_d      = rpt_cap;
                    last_bit_d = sync_data;
                    // a stuck source wins over a completed word
                    if (rpt_cap == RPT_LIM) begin
                        state_d = S_ERR;
                    end else if (bit_cnt_q == LAST_BIT) begin
                        state_d = S_PUSH;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_PUSH: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (out_ready) begin
                    cnt_d     = n_q - 16'd1;
                    bit_cnt_d = '0;
                    if (stop_pend_q || stop) begin
                        state_d     = S_IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d = S_SAMPLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        en_d = (state_d == S_WARMUP) || (state_d == S_SAMPLE) || (state_d == S_PUSH);
    end

    always_ff @(posedge rng_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rpt_q       <= '0;
            last_bit_q  <= 1'b0;
            stop_pend_q <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rpt_q       <= rpt_d;
            last_bit_q  <= last_bit_d;
            stop_pend_q <= stop_pend_d;
            en_q        <= en_d;
        end
    end

    assign rnd_src_en = en_q;
    assign out_valid  = (state_q == S_PUSH);
    assign out_data   = shift_q;
    assign busy       = (state_q == S_WARMUP) || (state_q == S_SAMPLE) || (state_q == S_PUSH);
    // ERR is left only through start, which also clears the flag
    assign err_stuck  = (state_q == S_ERR);

endmodule

// File: tb/tb_trng_sample_ctrl.sv
module tb_trng_sample_ctrl;
    localparam int WORD_W    = 32;
    localparam int RPT_LIMIT = 24;
    localparam int HMAX      = 32768;

    logic              rng_clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic [15:0]       sample_cnt;
    logic              rnd_src_en;
    logic              sync_valid;
    logic              sync_data;
    logic              out_valid;
    logic [WORD_W-1:0] out_data;
    logic              out_ready;
    logic              busy;
    logic              err_stuck;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int en_age = 0;
    bit force_invalid = 1'b0;
    int data_mode = 0;      // 0 random, 1 alternating per capture slot, 2 constant 0
    int alt_t0 = 0;
    int alt_n  = 1;
    bit have_t0 = 1'b0;
    bit hist [0:HMAX-1];
    logic [WORD_W-1:0] last_word;

    always #5 rng_clk = ~rng_clk;

    trng_sample_ctrl #(.WORD_W(WORD_W), .RPT_LIMIT(RPT_LIMIT)) dut (
        .rng_clk    (rng_clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .sample_cnt (sample_cnt),
        .rnd_src_en (rnd_src_en),
        .sync_valid (sync_valid),
        .sync_data  (sync_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .err_stuck  (err_stuck)
    );

    // Advance one clock; also models the synchronizer (valid 3 cycles after
    // enable) and the random bit stream, recording every driven bit by cycle.
    task automatic tick();
        @(posedge rng_clk);
        #1;
        cyc++;
        en_age = rnd_src_en ? en_age + 1 : 0;
        sync_valid = (en_age >= 3) && !force_invalid;
        if (!sync_valid) have_t0 = 1'b0;
        else if (!have_t0) begin
            have_t0 = 1'b1;
            alt_t0  = cyc + 1;
        end
        case (data_mode)
            1: sync_data = (have_t0 && cyc >= alt_t0 && (((cyc - alt_t0) / alt_n) % 2 == 0)) ? 1'b1 : 1'b0;
            2: sync_data = 1'b0;
            default: sync_data = 1'($urandom_range(0, 1));
        endcase
        if (cyc < HMAX) hist[cyc] = sync_data;
    endtask

    task automatic do_start(input logic [15:0] n);
        sample_cnt = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        sample_cnt = 16'($urandom);
        checks++;
        if (rnd_src_en !== 1'b1 || busy !== 1'b1 || err_stuck !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL start_enable: en=%b busy=%b err=%b vld=%b, required 1 1 0 0", rnd_src_en, busy, err_stuck, out_valid); end
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (rnd_src_en !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL stop_idle: en=%b busy=%b vld=%b, required 0 0 0", rnd_src_en, busy, out_valid); end
    endtask

    // Returns t0 = the cycle in which the block is expected to be in SAMPLE.
    task automatic wait_sample(output int t0);
        int guard;
        guard = 0;
        while (sync_valid !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (sync_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL warmup_timeout: no sync_valid after %0d cycles, required within 20", guard);
        end
        t0 = cyc + 1;
    endtask

    // Reference: with SAMPLE entered at t0, bit k (1-based) is the stream bit at
    // t0+k*n-1, packed MSB first; the word is offered at t0+WORD_W*n.
    task automatic expect_word(input int n, input int t0, input int stall, input int stop_at,
                               input string tag, output int nxt);
        int vcyc;
        bit early;
        logic [WORD_W-1:0] exp_w, held;
        vcyc  = t0 + WORD_W * n;
        early = 1'b0;
        while (cyc < vcyc) begin
            if (out_valid !== 1'b0) early = 1'b1;
            tick();
        end
        checks++;
        if (early) begin errors++; $display("FAIL %s_early_valid: out_valid=1 before cycle %0d, required 0", tag, vcyc); end
        exp_w = '0;
        for (int k = 1; k <= WORD_W; k++) exp_w = {exp_w[WORD_W-2:0], hist[t0 + k * n - 1]};
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_w)
            begin errors++; $display("FAIL %s_word: out_valid=%b out_data=%h, required 1 %h", tag, out_valid, out_data, exp_w); end
        last_word = out_data;
        held = out_data;
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            stop = (s == stop_at);
            tick();
            stop = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_data !== held)
                begin errors++; $display("FAIL %s_stall: out_valid=%b out_data=%h, required 1 %h", tag, out_valid, out_data, held); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drop: out_valid=%b after transfer, required 0", tag, out_valid); end
        nxt = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (rnd_src_en !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || err_stuck !== 1'b0)
            begin errors++; $display("FAIL reset_values: en=%b vld=%b data=%h busy=%b err=%b, required all 0", rnd_src_en, out_valid, out_data, busy, err_stuck); end
    endtask

    task automatic test_start_stop_same();
        start = 1'b1; stop = 1'b1; sample_cnt = 16'd1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || rnd_src_en !== 1'b0)
            begin errors++; $display("FAIL start_stop_same: busy=%b en=%b, required 0 0", busy, rnd_src_en); end
    endtask

    task automatic test_alternating(input logic [15:0] cnt, input int n, input string tag);
        int t0, nxt;
        data_mode = 1; alt_n = n;
        do_start(cnt);
        wait_sample(t0);
        expect_word(n, t0, 0, -1, tag, nxt);
        checks++;
        if (last_word !== 32'hAAAAAAAA) begin errors++; $display("FAIL %s_pattern: out_data=%h, required aaaaaaaa", tag, last_word); end
        checks++;
        if (err_stuck !== 1'b0) begin errors++; $display("FAIL %s_err: err_stuck=%b, required 0", tag, err_stuck); end
        do_stop();
        data_mode = 0;
    endtask

    task automatic test_back_to_back();
        int n, t;
        data_mode = 0;
        n = $urandom_range(2, 4);
        do_start(16'(n));
        wait_sample(t);
        for (int w = 0; w < 3; w++) expect_word(n, t, $urandom_range(0, 3), -1, "b2b", t);
        do_stop();
    endtask

    task automatic test_stuck();
        int n, t0, c, nxt;
        bit bad;
        data_mode = 2;
        n = $urandom_range(1, 3);
        do_start(16'(n));
        wait_sample(t0);
        c = t0 + RPT_LIMIT * n - 1;
        bad = 1'b0;
        while (cyc <= c) begin
            if (out_valid !== 1'b0 || err_stuck !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin errors++; $display("FAIL stuck_pre: out_valid or err_stuck high before capture %0d, required 0", RPT_LIMIT); end
        checks++;
        if (err_stuck !== 1'b1 || rnd_src_en !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL stuck_err: err=%b en=%b busy=%b vld=%b, required 1 0 0 0", err_stuck, rnd_src_en, busy, out_valid); end
        repeat (3) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        checks++;
        if (err_stuck !== 1'b1 || rnd_src_en !== 1'b0)
            begin errors++; $display("FAIL stuck_sticky: err=%b en=%b, required 1 0", err_stuck, rnd_src_en); end
        data_mode = 0;
        do_start(16'd1);
        wait_sample(t0);
        expect_word(1, t0, 0, -1, "after_err", nxt);
        do_stop();
    endtask

    task automatic test_stall_stop();
        int t0, nxt;
        data_mode = 0;
        do_start(16'd2);
        wait_sample(t0);
        expect_word(2, t0, 10, 5, "stall_stop", nxt);
        checks++;
        if (busy !== 1'b0 || rnd_src_en !== 1'b0)
            begin errors++; $display("FAIL stall_stop_idle: busy=%b en=%b, required 0 0", busy, rnd_src_en); end
    endtask

    task automatic test_stop_mid();
        int n, t0;
        bit bad;
        data_mode = 0;
        n = $urandom_range(1, 3);
        do_start(16'(n));
        wait_sample(t0);
        while (cyc < t0 + 10 * n - 1) tick();
        do_stop();
        bad = 1'b0;
        repeat (WORD_W * n + 5) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL stop_mid_quiet: out_valid or busy high after stop, required 0"); end
    endtask

    task automatic test_sync_drop();
        int t0, t1, nxt;
        data_mode = 0;
        do_start(16'd1);
        wait_sample(t0);
        while (cyc < t0 + 15) tick();
        force_invalid = 1'b1;
        tick();
        force_invalid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || rnd_src_en !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL sync_drop_warmup: busy=%b en=%b vld=%b, required 1 1 0", busy, rnd_src_en, out_valid); end
        wait_sample(t1);
        expect_word(1, t1, 0, -1, "sync_drop", nxt);
        do_stop();
    endtask

    task automatic test_reset_in_push();
        int t0, nxt;
        data_mode = 0;
        do_start(16'd1);
        wait_sample(t0);
        while (cyc < t0 + WORD_W) tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_push_pre: out_valid=%b, required 1", out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rnd_src_en !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || err_stuck !== 1'b0)
            begin errors++; $display("FAIL rst_push: en=%b vld=%b data=%h busy=%b err=%b, required all 0", rnd_src_en, out_valid, out_data, busy, err_stuck); end
        do_start(16'd3);
        wait_sample(t0);
        expect_word(3, t0, 1, -1, "after_rst", nxt);
        do_stop();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; sample_cnt = 16'd0;
        sync_valid = 1'b0; sync_data = 1'b0; out_ready = 1'b0;
        test_reset();
        test_start_stop_same();
        test_alternating(16'd1, 1, "alt_n1");
        test_alternating(16'd0, 1, "alt_n0");
        test_alternating(16'd4, 4, "alt_n4");
        test_back_to_back();
        test_stuck();
        test_stall_stop();
        test_stop_mid();
        test_sync_drop();
        test_reset_in_push();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
